// File: rtl/parity_stream_workelement.sv
// CAPI parity work element: fetches a WED, XORs NUM_STRIPES source lines per 128-byte line,
// writes each parity line back and finishes with a status word written into the WED.
module parity_stream_workelement #(
  parameter int unsigned NUM_STRIPES   = 2,   // legal range 2..14
  parameter int unsigned STATUS_OFFSET = 120
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic [63:0]  job_address,
  input  logic [7:0]   command_room,
  output logic         command_valid,
  output logic [12:0]  command_code,
  output logic         command_code_parity,
  output logic [7:0]   command_tag,
  output logic         command_tag_parity,
  output logic [63:0]  command_address,
  output logic         command_address_parity,
  output logic [11:0]  command_size,
  output logic [2:0]   command_abt,
  output logic [15:0]  command_context_handle,
  input  logic         buffer_write_valid,
  input  logic [7:0]   buffer_write_tag,
  input  logic [5:0]   buffer_write_address,
  input  logic [511:0] buffer_write_data,
  input  logic         buffer_read_valid,
  input  logic [7:0]   buffer_read_tag,
  input  logic [5:0]   buffer_read_address,
  output logic [511:0] buffer_read_data,
  output logic [7:0]   buffer_read_parity,
  output logic [3:0]   buffer_read_latency,
  input  logic         response_valid,
  input  logic [7:0]   response_tag,
  input  logic [7:0]   response_code,
  output logic         busy,
  output logic         error,
  output logic [31:0]  lines_done
);

  localparam int unsigned StripeW = $clog2(NUM_STRIPES);
  localparam logic [12:0] CmdReadClNa = 13'h0a00;
  localparam logic [12:0] CmdWriteNa  = 13'h0d00;
  localparam logic [7:0]  TagWed      = 8'h00;
  localparam logic [7:0]  TagParity   = 8'h20;
  localparam logic [7:0]  TagStatus   = 8'h21;

  typedef enum logic [3:0] {
    StIdle, StWedReq, StWedWait, StReadReq, StReadWait,
    StWriteReq, StWriteWait, StStatusReq, StStatusWait, StFinished
  } state_e;

  state_e state_q, state_d;

  logic [StripeW-1:0] stripe_q;
  logic [63:0]        offset_q, size_q, parity_ptr_q;
  logic [63:0]        stripe_ptr_q [NUM_STRIPES];
  logic [511:0]       acc_q [2];
  logic               cmd_valid_q;
  logic [12:0]        cmd_code_q;
  logic [7:0]         cmd_tag_q;
  logic [63:0]        cmd_addr_q;
  logic [11:0]        cmd_size_q;
  logic [511:0]       read_data_q;
  logic               error_q;
  logic [31:0]        lines_q;

  logic        is_req, is_wait, issue, resp_hit, resp_ok, last_stripe, last_line;
  logic [7:0]  wait_tag;
  logic [64:0] next_offset, size_round;

  logic unused_addr;
  assign unused_addr = ^{buffer_write_address[5:1], buffer_read_address[5:1]};

  // Memory is little-endian, while byte 0 of a beat sits in the top bits of the bus.
  function automatic logic [63:0] swap64(input logic [63:0] v);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = v[56-8*b +: 8];
    return r;
  endfunction

  always_comb begin
    is_req  = state_q inside {StWedReq, StReadReq, StWriteReq, StStatusReq};
    is_wait = state_q inside {StWedWait, StReadWait, StWriteWait, StStatusWait};
    issue   = enable && is_req && (command_room != 8'd0);
    case (state_q)
      StReadWait:   wait_tag = 8'(stripe_q) + 8'd1;
      StWriteWait:  wait_tag = TagParity;
      StStatusWait: wait_tag = TagStatus;
      default:      wait_tag = TagWed;
    endcase
    resp_hit    = enable && is_wait && response_valid && (response_tag == wait_tag);
    resp_ok     = response_code == 8'h00;
    last_stripe = stripe_q == StripeW'(NUM_STRIPES - 1);
    // 65-bit compare so an offset wrap past 2^64 also counts as covering the size
    next_offset = {1'b0, offset_q} + 65'd128;
    size_round  = ({1'b0, size_q} + 65'd127) & ~65'd127;
    last_line   = next_offset >= size_round;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:      if (enable) state_d = StWedReq;
      StWedReq:    if (issue) state_d = StWedWait;
      StWedWait:   if (resp_hit) state_d = (!resp_ok || size_q == 64'd0) ? StStatusReq : StReadReq;
      StReadReq:   if (issue) state_d = StReadWait;
      StReadWait:  if (resp_hit) state_d = !resp_ok ? StStatusReq :
                                           last_stripe ? StWriteReq : StReadReq;
      StWriteReq:  if (issue) state_d = StWriteWait;
      StWriteWait: if (resp_hit) state_d = (!resp_ok || last_line) ? StStatusReq : StReadReq;
      StStatusReq: if (issue) state_d = StStatusWait;
      StStatusWait: if (resp_hit) state_d = StFinished;
      default:     state_d = state_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stripe_q     <= '0;
      offset_q     <= '0;
      size_q       <= '0;
      parity_ptr_q <= '0;
      for (int i = 0; i < NUM_STRIPES; i++) stripe_ptr_q[i] <= '0;
      acc_q[0]     <= '0;
      acc_q[1]     <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_code_q   <= '0;
      cmd_tag_q    <= '0;
      cmd_addr_q   <= '0;
      cmd_size_q   <= '0;
      read_data_q  <= '0;
      error_q      <= 1'b0;
      lines_q      <= '0;
    end else if (enable) begin
      cmd_valid_q <= issue;
      if (issue) begin
        case (state_q)
          StWedReq: begin
            cmd_code_q <= CmdReadClNa; cmd_tag_q <= TagWed;
            cmd_addr_q <= job_address; cmd_size_q <= 12'd128;
          end
          StReadReq: begin
            cmd_code_q <= CmdReadClNa; cmd_tag_q <= 8'(stripe_q) + 8'd1;
            cmd_addr_q <= stripe_ptr_q[stripe_q] + offset_q; cmd_size_q <= 12'd128;
          end
          StWriteReq: begin
            cmd_code_q <= CmdWriteNa; cmd_tag_q <= TagParity;
            cmd_addr_q <= parity_ptr_q + offset_q; cmd_size_q <= 12'd128;
          end
          default: begin
            cmd_code_q <= CmdWriteNa; cmd_tag_q <= TagStatus;
            cmd_addr_q <= job_address + 64'(STATUS_OFFSET); cmd_size_q <= 12'd8;
          end
        endcase
      end
      if (state_q == StWedWait && buffer_write_valid && buffer_write_tag == TagWed) begin
        if (!buffer_write_address[0]) begin
          size_q       <= swap64(buffer_write_data[511 -: 64]);
          parity_ptr_q <= swap64(buffer_write_data[447 -: 64]);
        end
        for (int i = 0; i < NUM_STRIPES; i++) begin
          if (buffer_write_address[0] == 1'((16 + 8 * i) / 64))
            stripe_ptr_q[i] <= swap64(buffer_write_data[511 - 8 * ((16 + 8 * i) % 64) -: 64]);
        end
      end
      if (state_q == StReadWait && buffer_write_valid && buffer_write_tag == wait_tag) begin
        acc_q[buffer_write_address[0]] <= (stripe_q == '0) ? buffer_write_data :
                                          acc_q[buffer_write_address[0]] ^ buffer_write_data;
      end
      if (state_q == StWriteWait && buffer_read_valid && buffer_read_tag == TagParity)
        read_data_q <= acc_q[buffer_read_address[0]];
      if (state_q == StStatusReq)
        read_data_q <= {swap64(error_q ? 64'd2 : 64'd1), 448'd0};
      if (resp_hit) begin
        if (!resp_ok) begin
          if (state_q != StStatusWait) error_q <= 1'b1;
        end else begin
          case (state_q)
            StWedWait:   stripe_q <= '0;
            StReadWait:  stripe_q <= last_stripe ? '0 : stripe_q + 1'b1;
            StWriteWait: begin
              lines_q  <= lines_q + 32'd1;
              offset_q <= next_offset[63:0];
              stripe_q <= '0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    busy                   = !(state_q inside {StIdle, StFinished});
    command_valid          = cmd_valid_q && enable;
    command_code           = cmd_code_q;
    command_code_parity    = ~^cmd_code_q;
    command_tag            = cmd_tag_q;
    command_tag_parity     = ~^cmd_tag_q;
    command_address        = cmd_addr_q;
    command_address_parity = ~^cmd_addr_q;
    command_size           = cmd_size_q;
    command_abt            = 3'd0;
    command_context_handle = 16'd0;
    buffer_read_data       = read_data_q;
    buffer_read_latency    = 4'd1;
    for (int k = 0; k < 8; k++) buffer_read_parity[k] = ~^read_data_q[511-64*k -: 64];
    error                  = error_q;
    lines_done             = lines_q;
  end

endmodule

// File: tb/tb_parity_stream_workelement.sv
// Bench for parity_stream_workelement: a PSL/host-memory model serves commands and the
// resulting memory image and command log are compared against a line-level XOR model.
module tb_parity_stream_workelement;

  localparam int NS = 4;
  localparam int StatusOff = 120;
  localparam logic [12:0] ReadCl  = 13'h0a00;
  localparam logic [12:0] WriteNa = 13'h0d00;

  logic clock = 1'b0, reset = 1'b0, enable = 1'b0;
  logic [63:0] job_address = '0;
  logic [7:0] room_val = 8'd4;
  logic command_valid, command_code_parity, command_tag_parity, command_address_parity;
  logic [12:0] command_code;
  logic [7:0] command_tag;
  logic [63:0] command_address;
  logic [11:0] command_size;
  logic [2:0] command_abt;
  logic [15:0] command_context_handle;
  logic bwv = 1'b0, brv = 1'b0, rv = 1'b0;
  logic [7:0] bwtag = '0, brtag = '0, rtag = '0, rcode = '0;
  logic [5:0] bwaddr = '0, braddr = '0;
  logic [511:0] bwdata = '0;
  logic [511:0] buffer_read_data;
  logic [7:0] buffer_read_parity;
  logic [3:0] buffer_read_latency;
  logic busy, error;
  logic [31:0] lines_done;

  always #5 clock = ~clock;

  parity_stream_workelement #(.NUM_STRIPES(NS), .STATUS_OFFSET(StatusOff)) dut (
    .clock(clock), .reset(reset), .enable(enable), .job_address(job_address),
    .command_room(room_val), .command_valid(command_valid), .command_code(command_code),
    .command_code_parity(command_code_parity), .command_tag(command_tag),
    .command_tag_parity(command_tag_parity), .command_address(command_address),
    .command_address_parity(command_address_parity), .command_size(command_size),
    .command_abt(command_abt), .command_context_handle(command_context_handle),
    .buffer_write_valid(bwv), .buffer_write_tag(bwtag), .buffer_write_address(bwaddr),
    .buffer_write_data(bwdata), .buffer_read_valid(brv), .buffer_read_tag(brtag),
    .buffer_read_address(braddr), .buffer_read_data(buffer_read_data),
    .buffer_read_parity(buffer_read_parity), .buffer_read_latency(buffer_read_latency),
    .response_valid(rv), .response_tag(rtag), .response_code(rcode),
    .busy(busy), .error(error), .lines_done(lines_done)
  );

  typedef struct packed {
    logic [12:0] code;
    logic [7:0]  tag;
    logic [11:0] size;
    logic [63:0] addr;
  } cmd_t;

  cmd_t pending[$], log_q[$], exp_q[$];
  logic [1023:0] mem [logic [63:0]];
  int tests = 0, fails = 0;
  bit outstanding = 1'b0;
  int fail_tag = -1, fail_nth = 0;
  int tag_seen [256];
  bit starve = 1'b0, starved = 1'b0;
  logic [63:0] cur_wed, cur_par, cur_size;
  logic [63:0] cur_str [NS];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit oddp(input logic [63:0] v);
    return ($countones(v) % 2) == 0;
  endfunction

  function automatic logic [7:0] par8(input logic [511:0] h);
    logic [7:0] p;
    for (int k = 0; k < 8; k++) p[k] = oddp(h[511-64*k -: 64]);
    return p;
  endfunction

  function automatic logic [1023:0] rd_line(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  // Host memory line: byte j lives at bits [1023-8j -: 8]; 64-bit fields are little-endian.
  function automatic logic [1023:0] put64(input logic [1023:0] l, input int off,
                                          input logic [63:0] v);
    for (int b = 0; b < 8; b++) l[1023-8*(off+b) -: 8] = v[8*b +: 8];
    return l;
  endfunction

  function automatic logic [63:0] get64(input logic [1023:0] l, input int off);
    logic [63:0] v;
    for (int b = 0; b < 8; b++) v[8*b +: 8] = l[1023-8*(off+b) -: 8];
    return v;
  endfunction

  function automatic logic [1023:0] rand_line();
    logic [1023:0] v;
    for (int k = 0; k < 32; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  always @(negedge clock) begin
    cmd_t c;
    if (command_valid) begin
      c = '{code: command_code, tag: command_tag, size: command_size, addr: command_address};
      check("single_outstanding", 256'(outstanding), 256'(0));
      check("cmd_parity", {command_code_parity, command_tag_parity, command_address_parity},
            {oddp(64'(command_code)), oddp(64'(command_tag)), oddp(command_address)});
      outstanding = 1'b1;
      pending.push_back(c);
      log_q.push_back(c);
    end
  end

  task automatic serve(input cmd_t c);
    logic [1023:0] line;
    logic [511:0] h0, h1;
    logic [7:0] code;
    int off;
    code = 8'h00;
    h1 = '0;
    if (c.code == ReadCl) begin
      line = rd_line(c.addr);
      for (int h = 0; h < 2; h++) begin
        #1 bwv = 1'b1; bwtag = c.tag; bwaddr = 6'(h); bwdata = line[1023-512*h -: 512];
        @(posedge clock);
      end
      #1 bwv = 1'b0;
      if (int'(c.tag) == fail_tag) begin
        if (tag_seen[c.tag] == fail_nth) code = 8'h01;
        tag_seen[c.tag]++;
      end
    end else begin
      #1 brv = 1'b1; brtag = c.tag; braddr = 6'd0;
      @(posedge clock); #1;
      h0 = buffer_read_data;
      check("rd_parity_h0", buffer_read_parity, par8(h0));
      if (c.size == 12'd128) begin
        braddr = 6'd1;
        @(posedge clock); #1;
        h1 = buffer_read_data;
        check("rd_parity_h1", buffer_read_parity, par8(h1));
      end
      brv = 1'b0;
      if (c.size == 12'd128) mem[c.addr] = {h0, h1};
      else begin
        line = rd_line({c.addr[63:7], 7'd0});
        off = int'(c.addr[6:0]);
        for (int b = 0; b < 8; b++) line[1023-8*(off+b) -: 8] = h0[511-8*b -: 8];
        mem[{c.addr[63:7], 7'd0}] = line;
      end
    end
    rv = 1'b1; rtag = c.tag; rcode = code;
    if (c.tag == 8'h00 && starve) begin
      room_val = 8'd0;
      starved = 1'b1;
    end
    @(posedge clock); #1 rv = 1'b0;
    outstanding = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clock);
      if (pending.size() != 0) begin
        cmd_t c;
        c = pending.pop_front();
        serve(c);
      end
    end
  end

  task automatic setup(input int job, input logic [63:0] size, input bit fixed);
    logic [1023:0] w;
    logic [63:0] base;
    base = 64'(job) << 24;
    cur_wed = base + 64'h80000;
    cur_par = base + 64'h40000;
    cur_size = size;
    w = '0;
    w = put64(w, 0, size);
    w = put64(w, 8, cur_par);
    for (int i = 0; i < NS; i++) begin
      cur_str[i] = base + 64'(i) * 64'h4000;
      w = put64(w, 16 + 8 * i, cur_str[i]);
      for (int l = 0; l < 8; l++)
        mem[cur_str[i] + 64'(128 * l)] = !fixed ? rand_line() :
            (i == 0) ? {128{8'haa}} : (i == 1) ? {128{8'h55}} : '0;
    end
    mem[cur_wed] = w;
    job_address = cur_wed;
    for (int t = 0; t < 256; t++) tag_seen[t] = 0;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    reset = 1'b0;
    repeat (20) @(negedge clock);
    log_q.delete();
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic wait_done();
    bit done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clock);
      if (c > 2 && !busy) done = 1'b1;
    end
    check("job_done", 256'(done), 256'(1));
  endtask

  // Expected results from the WED contents: nl parity lines, then `abort` reads of a failed line.
  task automatic expect_job(input int nl, input int abort, input logic [63:0] status,
                            input bit err);
    logic [1023:0] exp_line, got_line;
    exp_q.delete();
    exp_q.push_back('{code: ReadCl, tag: 8'h00, size: 12'd128, addr: cur_wed});
    for (int l = 0; l <= nl; l++) begin
      for (int i = 0; i < ((l < nl) ? NS : abort); i++)
        exp_q.push_back('{code: ReadCl, tag: 8'(i + 1), size: 12'd128,
                          addr: cur_str[i] + 64'(128 * l)});
      if (l < nl)
        exp_q.push_back('{code: WriteNa, tag: 8'h20, size: 12'd128,
                          addr: cur_par + 64'(128 * l)});
    end
    exp_q.push_back('{code: WriteNa, tag: 8'h21, size: 12'd8, addr: cur_wed + StatusOff});
    check("lines_done", lines_done, nl);
    check("error", error, err);
    check("status_word", get64(rd_line(cur_wed), StatusOff), status);
    for (int l = 0; l < nl; l++) begin
      exp_line = '0;
      for (int i = 0; i < NS; i++) exp_line ^= rd_line(cur_str[i] + 64'(128 * l));
      got_line = rd_line(cur_par + 64'(128 * l));
      for (int q = 0; q < 4; q++)
        check($sformatf("parity_l%0d_q%0d", l, q), got_line[1023-256*q -: 256],
              exp_line[1023-256*q -: 256]);
    end
    check("cmd_count", log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      check($sformatf("cmd%0d", i), 256'(log_q[i]), 256'(exp_q[i]));
  endtask

  initial begin
    int n0, sz;
    bit seen;
    logic [1023:0] pl;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_lines", lines_done, 0);
    check("rst_valid", command_valid, 0);
    check("rst_rdata", buffer_read_data[255:0], 0);
    check("rst_latency", buffer_read_latency, 1);
    check("rst_abt_ctx", {command_abt, command_context_handle}, 0);
    reset = 1'b1;
    @(negedge clock);

    // Two patterned stripes against zero stripes: every parity byte is 0xFF
    setup(1, 64'd128, 1'b1);
    enable = 1'b1;
    wait_done();
    pl = rd_line(cur_par);
    check("parity_all_ff", pl[1023 -: 256], {32{8'hff}});
    expect_job(1, 0, 64'd1, 1'b0);
    do_reset();

    setup(2, 64'd300, 1'b0);
    enable = 1'b1;
    wait_done();
    expect_job(3, 0, 64'd1, 1'b0);
    do_reset();

    setup(3, 64'd0, 1'b0);
    enable = 1'b1;
    wait_done();
    expect_job(0, 0, 64'd1, 1'b0);
    do_reset();

    // Credit starvation right after the WED fetch
    starve = 1'b1;
    starved = 1'b0;
    setup(4, 64'd128, 1'b0);
    enable = 1'b1;
    for (int c = 0; c < 200 && !starved; c++) @(negedge clock);
    check("starve_reached", 256'(starved), 256'(1));
    n0 = log_q.size();
    repeat (20) @(negedge clock);
    check("starve_no_cmd", log_q.size(), n0);
    starve = 1'b0;
    room_val = 8'd1;
    @(negedge clock); #1;
    check("starve_one_cmd", log_q.size(), n0 + 1);
    room_val = 8'd4;
    wait_done();
    expect_job(1, 0, 64'd1, 1'b0);
    do_reset();

    // Stripe-1 read (tag 2) of the second line returns FAILED
    setup(5, 64'd384, 1'b0);
    fail_tag = 2;
    fail_nth = 1;
    enable = 1'b1;
    wait_done();
    expect_job(1, 2, 64'd2, 1'b1);
    fail_tag = -1;
    do_reset();

    // Asynchronous reset in the middle of a stripe read, then a fresh start
    setup(6, 64'd256, 1'b0);
    enable = 1'b1;
    for (int c = 0; c < 200 && log_q.size() < 2; c++) @(negedge clock);
    check("reached_read", log_q.size(), 2);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_valid", command_valid, 0);
    check("async_rdata", buffer_read_data[511 -: 256], 0);
    enable = 1'b0;
    repeat (20) @(negedge clock);
    log_q.delete();
    reset = 1'b1;
    @(negedge clock);
    enable = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clock); #1;
      seen = log_q.size() != 0;
    end
    check("refetch_wed", seen ? {log_q[0].tag, log_q[0].addr} : 72'hff, {8'h00, cur_wed});
    wait_done();
    expect_job(2, 0, 64'd1, 1'b0);
    do_reset();

    sz = int'($urandom_range(1, 900));
    setup(7, 64'(sz), 1'b0);
    enable = 1'b1;
    wait_done();
    expect_job((sz + 127) / 128, 0, 64'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
